// File: rtl/backend_pipe_ctrl.sv
// backend_pipe_ctrl: central stall/clear controller for the backend pipes.
//   Pipe 0 is the main (oldest) pipe, pipes 1..PIPE_NUM-1 are younger ALU pipes.
//   Stall/clear/issue outputs are combinational from the requests and FSM state.
//   An EX clear that arrives while M1 is stalled is held (HOLD) until M1 moves.
//   After any applied flush, issue is suppressed for BUBBLE_CYCLES cycles.
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   *_stall_req_i            per-pipe EX/M1/M2 stall requests
//   ex_clr_req_i             pipe-0 branch mispredict in EX
//   m2_clr_req_i             pipe-0 redirect in M2 (+ m2_clr_exclude_self_i)
//   issue_valid_i / issue_o  frontend packet ready / packet enters EX
//   stall_vec_o              {M2, M1, EX} stall shared by all pipes
//   clr_vec_o                per pipe 3 bits, bit k kills instr leaving stage k
//   frontend_flush_o         one-cycle frontend discard pulse
//   pending_o                a held EX clear is outstanding
// Optional: define BACKEND_PIPE_CTRL_PERF_EN to add perf_stall_cyc_o,
//   perf_flush_cnt_o and perf_hold_cyc_o (32-bit saturating counters).
module backend_pipe_ctrl #(
  parameter int PIPE_NUM      = 2,
  parameter int BUBBLE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PIPE_NUM-1:0]   ex_stall_req_i,
  input  logic [PIPE_NUM-1:0]   m1_stall_req_i,
  input  logic [PIPE_NUM-1:0]   m2_stall_req_i,
  input  logic                  ex_clr_req_i,
  input  logic                  m2_clr_req_i,
  input  logic                  m2_clr_exclude_self_i,
  input  logic                  issue_valid_i,
  output logic [2:0]            stall_vec_o,
  output logic [PIPE_NUM*3-1:0] clr_vec_o,
  output logic                  issue_o,
  output logic                  frontend_flush_o,
`ifdef BACKEND_PIPE_CTRL_PERF_EN
  output logic [31:0]           perf_stall_cyc_o,
  output logic [31:0]           perf_flush_cnt_o,
  output logic [31:0]           perf_hold_cyc_o,
`endif
  output logic                  pending_o
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HOLD   = 2'd1,
    ST_BUBBLE = 2'd2
  } state_e;

  localparam logic [1:0] BUB_INIT = 2'(BUBBLE_CYCLES);

  state_e                state_q, state_d;
  logic [1:0]            bub_q, bub_d;

  logic                  s0, s1, s2;
  logic [PIPE_NUM*3-1:0] clr_d;
  logic                  flush_d;

  // Stall propagates backwards: a stalled later stage stalls every earlier one.
  assign s2 = |m2_stall_req_i;
  assign s1 = s2 | (|m1_stall_req_i);
  assign s0 = s1 | (|ex_stall_req_i);

  always_comb begin
    state_d = state_q;
    bub_d   = bub_q;
    clr_d   = '0;
    flush_d = 1'b0;

    if (m2_clr_req_i) begin
      // M2 redirect is the oldest event: it overrides any EX request or held
      // clear and kills everything younger, in any state.
      for (int p = 0; p < PIPE_NUM; p++) begin
        clr_d[p*3 +: 3] = 3'b111;
      end
      clr_d[2] = ~m2_clr_exclude_self_i;
      flush_d  = 1'b1;
      state_d  = ST_BUBBLE;
      bub_d    = BUB_INIT;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (ex_clr_req_i) begin
            if (s1) begin
              state_d = ST_HOLD;
            end else begin
              // Branch in pipe 0 proceeds; younger same-stage instrs die.
              for (int p = 1; p < PIPE_NUM; p++) begin
                clr_d[p*3] = 1'b1;
              end
              flush_d = 1'b1;
              state_d = ST_BUBBLE;
              bub_d   = BUB_INIT;
            end
          end
        end
        ST_HOLD: begin
          // ex_clr_req_i is the same held branch here, so it is not re-sampled.
          if (!s1) begin
            for (int p = 1; p < PIPE_NUM; p++) begin
              clr_d[p*3] = 1'b1;
            end
            flush_d = 1'b1;
            state_d = ST_BUBBLE;
            bub_d   = BUB_INIT;
          end
        end
        ST_BUBBLE: begin
          if (bub_q <= 2'd1) begin
            state_d = ST_RUN;
            bub_d   = 2'd0;
          end else begin
            bub_d = bub_q - 2'd1;
          end
        end
        default: begin
          state_d = ST_RUN;
          bub_d   = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      bub_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      bub_q   <= bub_d;
    end
  end

  // Outputs are forced low while reset is asserted.
  assign stall_vec_o      = rst_n ? {s2, s1, s0} : 3'b000;
  assign clr_vec_o        = rst_n ? clr_d : '0;
  assign frontend_flush_o = rst_n & flush_d;
  assign pending_o        = rst_n & (state_q == ST_HOLD);
  assign issue_o          = rst_n & issue_valid_i & ~s0 & (state_q == ST_RUN) & ~flush_d;

`ifdef BACKEND_PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_q, perf_flush_q, perf_hold_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
      perf_hold_q  <= '0;
    end else begin
      if (s0 && perf_stall_q != 32'hFFFF_FFFF) perf_stall_q <= perf_stall_q + 32'd1;
      if (flush_d && perf_flush_q != 32'hFFFF_FFFF) perf_flush_q <= perf_flush_q + 32'd1;
      if (state_q == ST_HOLD && perf_hold_q != 32'hFFFF_FFFF) perf_hold_q <= perf_hold_q + 32'd1;
    end
  end

  assign perf_stall_cyc_o = perf_stall_q;
  assign perf_flush_cnt_o = perf_flush_q;
  assign perf_hold_cyc_o  = perf_hold_q;
`endif

endmodule

// File: tb/tb_backend_pipe_ctrl.sv
module tb_backend_pipe_ctrl;

  localparam int BUB = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] ex_st, m1_st, m2_st;
  logic       ex_clr, m2_clr, excl, iv;
  logic [2:0] stall_vec;
  logic [5:0] clr_vec;
  logic       issue, flush, pend;
`ifdef BACKEND_PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall, perf_flush, perf_hold;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  backend_pipe_ctrl #(.PIPE_NUM(2), .BUBBLE_CYCLES(BUB)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .ex_stall_req_i        (ex_st),
    .m1_stall_req_i        (m1_st),
    .m2_stall_req_i        (m2_st),
    .ex_clr_req_i          (ex_clr),
    .m2_clr_req_i          (m2_clr),
    .m2_clr_exclude_self_i (excl),
    .issue_valid_i         (iv),
    .stall_vec_o           (stall_vec),
    .clr_vec_o             (clr_vec),
    .issue_o               (issue),
    .frontend_flush_o      (flush),
`ifdef BACKEND_PIPE_CTRL_PERF_EN
    .perf_stall_cyc_o      (perf_stall),
    .perf_flush_cnt_o      (perf_flush),
    .perf_hold_cyc_o       (perf_hold),
`endif
    .pending_o             (pend)
  );

  typedef struct {
    logic       rst_n;
    logic [1:0] ex_st, m1_st, m2_st;
    logic       ex_clr, m2_clr, excl, iv;
    logic [2:0] e_stall;
    logic [5:0] e_clr;
    logic       e_issue, e_flush, e_pend;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [1:0] es, input logic [1:0] m1s,
                     input logic [1:0] m2s, input logic ec, input logic mc,
                     input logic ex, input logic v, input logic [2:0] st,
                     input logic [5:0] cl, input logic is, input logic fl, input logic pd);
    vec_t t;
    t.rst_n = r; t.ex_st = es; t.m1_st = m1s; t.m2_st = m2s;
    t.ex_clr = ec; t.m2_clr = mc; t.excl = ex; t.iv = v;
    t.e_stall = st; t.e_clr = cl; t.e_issue = is; t.e_flush = fl; t.e_pend = pd;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0d: got %0h want %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [1:0] es, input logic [1:0] m1s,
                       input logic [1:0] m2s, input logic ec, input logic mc,
                       input logic ex, input logic v);
    rst_n = r; ex_st = es; m1_st = m1s; m2_st = m2s;
    ex_clr = ec; m2_clr = mc; excl = ex; iv = v;
  endtask

  // Reference model: a pending flag and a count of bubble cycles still owed.
  bit          mdl_pend;
  int          mdl_bub;
  logic [2:0]  m_stall;
  logic [5:0]  m_clr;
  logic        m_issue, m_flush, m_pend;
  longint      m_pstall, m_pflush, m_phold;

  task automatic model_step();
    bit s0, s1, s2;
    bit nxt_pend;
    int nxt_bub;
    s2 = (m2_st != 0);
    s1 = s2 || (m1_st != 0);
    s0 = s1 || (ex_st != 0);
    m_clr = 0; m_flush = 0;
    nxt_pend = mdl_pend; nxt_bub = mdl_bub;
    if (!rst_n) begin
      m_stall = 0; m_issue = 0; m_pend = 0;
      nxt_pend = 0; nxt_bub = 0;
      m_pstall = 0; m_pflush = 0; m_phold = 0;
    end else begin
      m_stall = {s2, s1, s0};
      m_pend  = mdl_pend;
      if (m2_clr) begin
        m_clr = {3'b111, ~excl, 2'b11};
        m_flush = 1; nxt_pend = 0; nxt_bub = BUB;
      end else if (mdl_pend) begin
        if (!s1) begin
          m_clr = 6'b001_000; m_flush = 1; nxt_pend = 0; nxt_bub = BUB;
        end
      end else if (mdl_bub > 0) begin
        nxt_bub = mdl_bub - 1;
      end else if (ex_clr) begin
        if (s1) nxt_pend = 1;
        else begin
          m_clr = 6'b001_000; m_flush = 1; nxt_bub = BUB;
        end
      end
      m_issue = iv && !s0 && !mdl_pend && mdl_bub == 0 && !m_flush;
      if (s0) m_pstall++;
      if (m_flush) m_pflush++;
      if (mdl_pend) m_phold++;
    end
    mdl_pend = nxt_pend;
    mdl_bub  = nxt_bub;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    mdl_pend = 0; mdl_bub = 0;
    m_pstall = 0; m_pflush = 0; m_phold = 0;

    // rst ex m1 m2 exc m2c excl iv | stall clr iss fl pend
    add(0, 0, 0, 0, 0, 0, 0, 1, 3'b000, 6'b000000, 0, 0, 0); // in reset
    add(1, 0, 0, 0, 0, 0, 0, 1, 3'b000, 6'b000000, 1, 0, 0);
    add(1, 0, 0, 1, 0, 0, 0, 1, 3'b111, 6'b000000, 0, 0, 0); // 3-cycle M2 stall
    add(1, 0, 0, 1, 0, 0, 0, 1, 3'b111, 6'b000000, 0, 0, 0);
    add(1, 0, 0, 1, 0, 0, 0, 1, 3'b111, 6'b000000, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 1, 3'b000, 6'b000000, 1, 0, 0);
    add(1, 0, 2, 0, 0, 0, 0, 1, 3'b011, 6'b000000, 0, 0, 0); // M1 stall pipe 1
    add(1, 0, 0, 0, 1, 0, 0, 1, 3'b000, 6'b001000, 0, 1, 0); // EX clear unstalled
    add(1, 0, 0, 0, 0, 0, 0, 1, 3'b000, 6'b000000, 0, 0, 0); // bubble
    add(1, 0, 0, 0, 0, 0, 0, 1, 3'b000, 6'b000000, 1, 0, 0);
    add(1, 0, 0, 1, 1, 0, 0, 1, 3'b111, 6'b000000, 0, 0, 0); // EX clear under stall
    add(1, 0, 0, 1, 1, 0, 0, 1, 3'b111, 6'b000000, 0, 0, 1);
    add(1, 0, 0, 1, 1, 0, 0, 1, 3'b111, 6'b000000, 0, 0, 1);
    add(1, 0, 0, 1, 1, 0, 0, 1, 3'b111, 6'b000000, 0, 0, 1);
    add(1, 0, 0, 0, 1, 0, 0, 1, 3'b000, 6'b001000, 0, 1, 1); // held clear released
    add(1, 0, 0, 0, 0, 0, 0, 1, 3'b000, 6'b000000, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 1, 3'b000, 6'b000000, 1, 0, 0);
    add(1, 0, 1, 0, 1, 0, 0, 1, 3'b011, 6'b000000, 0, 0, 0); // hold via M1 stall
    add(1, 0, 1, 0, 0, 0, 0, 1, 3'b011, 6'b000000, 0, 0, 1);
    add(1, 0, 1, 0, 0, 1, 1, 1, 3'b011, 6'b111011, 0, 1, 1); // M2 clear overrides
    add(1, 0, 0, 0, 0, 0, 0, 1, 3'b000, 6'b000000, 0, 0, 0); // no second flush
    add(1, 0, 0, 0, 0, 0, 0, 1, 3'b000, 6'b000000, 1, 0, 0);
    add(1, 0, 0, 1, 1, 0, 0, 1, 3'b111, 6'b000000, 0, 0, 0);
    add(1, 0, 0, 1, 0, 0, 0, 1, 3'b111, 6'b000000, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, 3'b000, 6'b000000, 0, 0, 0); // reset in HOLD
    add(1, 0, 0, 0, 0, 0, 0, 1, 3'b000, 6'b000000, 1, 0, 0);
    add(1, 0, 0, 0, 1, 1, 0, 1, 3'b000, 6'b111111, 0, 1, 0); // M2 + EX same cycle
    add(1, 0, 0, 0, 0, 1, 1, 1, 3'b000, 6'b111011, 0, 1, 0); // M2 clear in BUBBLE
    add(1, 0, 0, 0, 0, 0, 0, 1, 3'b000, 6'b000000, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 1, 3'b000, 6'b000000, 1, 0, 0);
    add(1, 2, 0, 0, 0, 0, 0, 1, 3'b001, 6'b000000, 0, 0, 0); // EX stall only

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst_n, vecs[i].ex_st, vecs[i].m1_st, vecs[i].m2_st,
            vecs[i].ex_clr, vecs[i].m2_clr, vecs[i].excl, vecs[i].iv);
      #2;
      chk("tbl_stall", i, 32'(stall_vec), 32'(vecs[i].e_stall));
      chk("tbl_clr",   i, 32'(clr_vec),   32'(vecs[i].e_clr));
      chk("tbl_issue", i, 32'(issue),     32'(vecs[i].e_issue));
      chk("tbl_flush", i, 32'(flush),     32'(vecs[i].e_flush));
      chk("tbl_pend",  i, 32'(pend),      32'(vecs[i].e_pend));
    end

    // Randomized run against the reference model, starting from reset.
    for (int c = 0; c < 2000; c++) begin
      logic [1:0] es, m1s, m2s;
      logic mc;
      @(negedge clk);
      es  = 2'(($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      m1s = 2'(($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0);
      m2s = 2'(($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0);
      // An M2 redirect never coincides with an M2 stall upstream.
      mc  = (m2s == 0) && ($urandom_range(0, 9) == 0);
      drive((c == 0) ? 1'b0 : ($urandom_range(0, 99) != 0), es, m1s, m2s,
            1'($urandom_range(0, 3) == 0), mc, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0));
      #2;
      model_step();
      chk("rnd_stall", c, 32'(stall_vec), 32'(m_stall));
      chk("rnd_clr",   c, 32'(clr_vec),   32'(m_clr));
      chk("rnd_issue", c, 32'(issue),     32'(m_issue));
      chk("rnd_flush", c, 32'(flush),     32'(m_flush));
      chk("rnd_pend",  c, 32'(pend),      32'(m_pend));
    end

`ifdef BACKEND_PIPE_CTRL_PERF_EN
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("perf_stall", 0, perf_stall, 32'(m_pstall));
    chk("perf_flush", 0, perf_flush, 32'(m_pflush));
    chk("perf_hold",  0, perf_hold,  32'(m_phold));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
